// File: rtl/ddr_pkg.sv
// ddr_pkg: shared definitions for the DDR request path.
//   - APP_CMD_RD / APP_CMD_WR : MIG app_cmd encodings
//   - ddr_state_e             : dispatcher state encoding
//   - ADDR_W_DEF / APP_DW_DEF : default address / app data widths
package ddr_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int APP_DW_DEF = 64;

  localparam logic [2:0] APP_CMD_RD = 3'b001;
  localparam logic [2:0] APP_CMD_WR = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_CMD = 3'd1,
    ST_WR_D0  = 3'd2,
    ST_WR_D1  = 3'd3,
    ST_WR_CMD = 3'd4
  } ddr_state_e;

endpackage

// File: rtl/ddr_fifo_to_app_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   en         : arbitration enable; gnt is all-zero while low
//   req[1:0]   : request vector
//   gnt[1:0]   : one-hot (or zero) grant, combinational from req/en
// The last-granted flag moves on every issued grant, so on a tie the side
// that did not win the previous grant wins. INIT_LAST is the flag value after
// reset (1 = requester 1 treated as last winner, so requester 0 wins the
// first tie).
module rr_arb2 #(
  parameter bit INIT_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;  // 1 = requester 1 won the most recent grant

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      last_q <= INIT_LAST;
    else if (|gnt)  last_q <= gnt[1];
  end

endmodule

// File: rtl/ddr_fifo_to_app.sv
// ddr_fifo_to_app: dispatches read/write requests from the DDR request FIFOs
// onto the MIG user (app) interface.
//   clk, reset                 : MIG ui_clk, synchronous active-high reset
//   init_calib_complete        : gates new grants only
//   f2a_has_rd_req/f2a_app_adx : read FIFO not-empty / FWFT head address
//   f2a_get_rd_adr             : read FIFO pop (1-cycle pulse)
//   f2a_has_wr_req/f2a_wr_adx/f2a_wr_data : write FIFO status / FWFT head
//   f2a_get_wr_req             : write FIFO pop (1-cycle pulse)
//   app_addr/app_cmd/app_en/app_rdy       : MIG command channel
//   app_wdf_data/wren/end/mask/rdy        : MIG write-data channel
//   busy                       : dispatcher not idle
//   rd_issued_cnt/wr_issued_cnt: accepted read/write commands, mod 2^32
//   state_dbg                  : current FSM state for observation
//
// Handshake: a transfer on either MIG channel happens on the rising edge where
// the block's enable (app_en / app_wdf_wren) and MIG's ready are both high.
// While enable is high and ready is low, address, command and data are held
// stable; the enable is never withdrawn before acceptance.
module ddr_fifo_to_app
  import ddr_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int APP_DW   = APP_DW_DEF,
  parameter int WR_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_calib_complete,
  input  logic                  f2a_has_rd_req,
  input  logic [ADDR_W-1:0]     f2a_app_adx,
  output logic                  f2a_get_rd_adr,
  input  logic                  f2a_has_wr_req,
  input  logic [ADDR_W-1:0]     f2a_wr_adx,
  input  logic [2*APP_DW-1:0]   f2a_wr_data,
  output logic                  f2a_get_wr_req,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [APP_DW-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [APP_DW/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  output logic                  busy,
  output logic [31:0]           rd_issued_cnt,
  output logic [31:0]           wr_issued_cnt,
  output logic [2:0]            state_dbg
);

  ddr_state_e state_q, state_nx;

  logic [ADDR_W-1:0]   addr_q;
  logic [2*APP_DW-1:0] data_q;
  logic [2:0]          cmd_q;
  logic [31:0]         rd_cnt_q, wr_cnt_q;

  logic       arb_en;
  logic [1:0] gnt;  // [0] = read, [1] = write

  // Grants are only offered from IDLE with calibration done. Reset is folded
  // in so the pops stay low while the upstream FIFOs are being cleared.
  assign arb_en = (state_q == ST_IDLE) && init_calib_complete && !reset;

  rr_arb2 #(
    .INIT_LAST(WR_FIRST == 0)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .en   (arb_en),
    .req  ({f2a_has_wr_req, f2a_has_rd_req}),
    .gnt  (gnt)
  );

  assign f2a_get_rd_adr = gnt[0];
  assign f2a_get_wr_req = gnt[1];

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0])      state_nx = ST_RD_CMD;
        else if (gnt[1]) state_nx = ST_WR_D0;
      end
      ST_RD_CMD: if (app_rdy)     state_nx = ST_IDLE;
      ST_WR_D0:  if (app_wdf_rdy) state_nx = ST_WR_D1;
      ST_WR_D1:  if (app_wdf_rdy) state_nx = ST_WR_CMD;
      ST_WR_CMD: if (app_rdy)     state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      cmd_q    <= APP_CMD_WR;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_nx;
      // The popped FIFO head is captured on the grant edge; the FIFO moves on
      // to its next entry in the same cycle.
      if (gnt[0]) begin
        addr_q <= f2a_app_adx;
        cmd_q  <= APP_CMD_RD;
      end else if (gnt[1]) begin
        addr_q <= f2a_wr_adx;
        data_q <= f2a_wr_data;
        cmd_q  <= APP_CMD_WR;
      end
      if (state_q == ST_RD_CMD && app_rdy) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (state_q == ST_WR_CMD && app_rdy) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign app_en       = (state_q == ST_RD_CMD) || (state_q == ST_WR_CMD);
  assign app_wdf_wren = (state_q == ST_WR_D0)  || (state_q == ST_WR_D1);
  assign app_wdf_end  = (state_q == ST_WR_D1);
  assign app_wdf_data = (state_q == ST_WR_D1) ? data_q[2*APP_DW-1:APP_DW]
                                              : data_q[APP_DW-1:0];
  assign app_wdf_mask = '0;
  assign app_addr     = addr_q;
  assign app_cmd      = cmd_q;
  assign busy         = (state_q != ST_IDLE);
  assign rd_issued_cnt = rd_cnt_q;
  assign wr_issued_cnt = wr_cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ddr_fifo_to_app.sv
// tb_ddr_fifo_to_app: randomized scoreboard bench for ddr_fifo_to_app.
// The bench owns two request FIFOs (queues). When the DUT pops one, the
// expected MIG traffic for that request is pushed onto expectation queues and
// a separate monitor pops and compares them at each MIG handshake. A small
// grant model (idle flag + last-winner flag) predicts every pop.
module tb_ddr_fifo_to_app;
  import ddr_pkg::*;

  localparam int ADDR_W = 27;
  localparam int APP_DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset = 1'b1;
  logic                  init_calib_complete = 1'b0;
  logic                  f2a_has_rd_req = 1'b0;
  logic [ADDR_W-1:0]     f2a_app_adx = '0;
  logic                  f2a_get_rd_adr;
  logic                  f2a_has_wr_req = 1'b0;
  logic [ADDR_W-1:0]     f2a_wr_adx = '0;
  logic [2*APP_DW-1:0]   f2a_wr_data = '0;
  logic                  f2a_get_wr_req;
  logic [ADDR_W-1:0]     app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy = 1'b1;
  logic [APP_DW-1:0]     app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [APP_DW/8-1:0]   app_wdf_mask;
  logic                  app_wdf_rdy = 1'b1;
  logic                  busy;
  logic [31:0]           rd_issued_cnt;
  logic [31:0]           wr_issued_cnt;
  logic [2:0]            state_dbg;

  ddr_fifo_to_app #(
    .ADDR_W  (ADDR_W),
    .APP_DW  (APP_DW),
    .WR_FIRST(0)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .init_calib_complete(init_calib_complete),
    .f2a_has_rd_req     (f2a_has_rd_req),
    .f2a_app_adx        (f2a_app_adx),
    .f2a_get_rd_adr     (f2a_get_rd_adr),
    .f2a_has_wr_req     (f2a_has_wr_req),
    .f2a_wr_adx         (f2a_wr_adx),
    .f2a_wr_data        (f2a_wr_data),
    .f2a_get_wr_req     (f2a_get_wr_req),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_rdy            (app_rdy),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_wdf_mask       (app_wdf_mask),
    .app_wdf_rdy        (app_wdf_rdy),
    .busy               (busy),
    .rd_issued_cnt      (rd_issued_cnt),
    .wr_issued_cnt      (wr_issued_cnt),
    .state_dbg          (state_dbg)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0]            rd_fifo[$];
  logic [ADDR_W+2*APP_DW-1:0]   wr_fifo[$];   // {addr, beat1, beat0}
  logic [ADDR_W+2:0]            exp_cmd_q[$]; // {cmd, addr}
  logic [APP_DW:0]              exp_wdf_q[$]; // {end, data}
  logic                         pop_log[$];   // 0 = read pop, 1 = write pop

  int app_rdy_pct = 100;
  int wdf_rdy_pct = 100;
  int app_hold    = 0;   // force app_rdy low for this many app_en cycles
  int wdf_hold    = 0;   // force app_wdf_rdy low for this many wren cycles

  bit m_idle    = 1'b1;  // model: dispatcher can grant
  bit m_last_wr = 1'b1;  // model: last grant was a write (read wins first tie)
  int rd_total  = 0;
  int wr_total  = 0;
  int m_rd_cnt  = 0;
  int m_wr_cnt  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver: FIFO model, pop prediction, ready stimulus ----------------
  initial begin : engine
    logic pr, pw, prev_r, prev_w;
    bit exp_any, exp_wr;
    logic [ADDR_W+2*APP_DW-1:0] we;
    prev_r = 1'b0;
    prev_w = 1'b0;
    forever begin
      @(negedge clk);
      pr = 1'b0;
      pw = 1'b0;
      if (!reset) begin
        pr = f2a_get_rd_adr;
        pw = f2a_get_wr_req;
        chk("busy", 256'(busy), 256'(!m_idle));
        if (prev_r) chk("rd_latency", 256'({app_en, app_cmd}), 256'({1'b1, APP_CMD_RD}));
        if (prev_w) chk("wr_latency", 256'({app_wdf_wren, app_wdf_end}), 256'(2'b10));
        exp_any = init_calib_complete && (f2a_has_rd_req || f2a_has_wr_req) && m_idle;
        exp_wr  = f2a_has_wr_req && (!f2a_has_rd_req || !m_last_wr);
        chk("pops", 256'({pw, pr}), 256'({exp_any && exp_wr, exp_any && !exp_wr}));
        if (app_en && app_rdy) m_idle = 1'b1;
        if (exp_any) begin
          m_idle    = 1'b0;
          m_last_wr = exp_wr;
        end
      end else begin
        m_idle    = 1'b1;
        m_last_wr = 1'b1;
      end
      prev_r = pr;
      prev_w = pw;

      @(posedge clk);
      #1;
      if (!reset) begin
        if (pr && rd_fifo.size() > 0) begin
          exp_cmd_q.push_back({APP_CMD_RD, rd_fifo.pop_front()});
          rd_total++;
          pop_log.push_back(1'b0);
        end
        if (pw && wr_fifo.size() > 0) begin
          we = wr_fifo.pop_front();
          exp_wdf_q.push_back({1'b0, we[APP_DW-1:0]});
          exp_wdf_q.push_back({1'b1, we[2*APP_DW-1:APP_DW]});
          exp_cmd_q.push_back({APP_CMD_WR, we[ADDR_W+2*APP_DW-1:2*APP_DW]});
          wr_total++;
          pop_log.push_back(1'b1);
        end
      end
      f2a_has_rd_req = (rd_fifo.size() != 0);
      f2a_app_adx    = (rd_fifo.size() != 0) ? rd_fifo[0] : '0;
      f2a_has_wr_req = (wr_fifo.size() != 0);
      we             = (wr_fifo.size() != 0) ? wr_fifo[0] : '0;
      f2a_wr_adx     = we[ADDR_W+2*APP_DW-1:2*APP_DW];
      f2a_wr_data    = we[2*APP_DW-1:0];
      if (app_en && app_hold > 0) begin
        app_rdy = 1'b0;
        app_hold--;
      end else begin
        app_rdy = ($urandom_range(99) < app_rdy_pct);
      end
      if (app_wdf_wren && wdf_hold > 0) begin
        app_wdf_rdy = 1'b0;
        wdf_hold--;
      end else begin
        app_wdf_rdy = ($urandom_range(99) < wdf_rdy_pct);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic p_en, p_rdy, p_wren, p_wrdy, p_end;
    logic [ADDR_W-1:0] p_addr;
    logic [2:0]        p_cmd;
    logic [APP_DW-1:0] p_wdata;
    logic [ADDR_W+2:0] ec;
    logic [APP_DW:0]   ew;
    p_en = 1'b0; p_rdy = 1'b0; p_wren = 1'b0; p_wrdy = 1'b0; p_end = 1'b0;
    p_addr = '0; p_cmd = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_rd_cnt = 0;
        m_wr_cnt = 0;
        p_en     = 1'b0;
        p_wren   = 1'b0;
      end else begin
        chk("rd_issued_cnt", 256'(rd_issued_cnt), 256'(32'(m_rd_cnt)));
        chk("wr_issued_cnt", 256'(wr_issued_cnt), 256'(32'(m_wr_cnt)));
        chk("wdf_mask", 256'(app_wdf_mask), 256'(0));
        if (p_en && !p_rdy)
          chk("cmd_hold", 256'({app_en, app_cmd, app_addr}), 256'({1'b1, p_cmd, p_addr}));
        if (p_wren && !p_wrdy)
          chk("wdf_hold", 256'({app_wdf_wren, app_wdf_end, app_wdf_data}),
              256'({1'b1, p_end, p_wdata}));
        if (app_en && app_rdy) begin
          chk("cmd_pending", 256'(exp_cmd_q.size() != 0), 256'(1));
          if (exp_cmd_q.size() != 0) begin
            ec = exp_cmd_q.pop_front();
            chk("cmd", 256'({app_cmd, app_addr}), 256'(ec));
            if (ec[ADDR_W+2:ADDR_W] == APP_CMD_RD) m_rd_cnt++;
            else                                  m_wr_cnt++;
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          chk("wdf_pending", 256'(exp_wdf_q.size() != 0), 256'(1));
          if (exp_wdf_q.size() != 0) begin
            ew = exp_wdf_q.pop_front();
            chk("wdf_beat", 256'({app_wdf_end, app_wdf_data}), 256'(ew));
          end
        end
        p_en = app_en;   p_rdy = app_rdy;   p_addr = app_addr;   p_cmd = app_cmd;
        p_wren = app_wdf_wren; p_wrdy = app_wdf_rdy; p_end = app_wdf_end; p_wdata = app_wdf_data;
      end
    end
  end

  // ---------------- main sequence ----------------
  // All main-sequence actions happen at posedge+2, after the driver's update.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic calib);
    reset = 1'b1;
    init_calib_complete = calib;
    rd_fifo.delete();
    wr_fifo.delete();
    exp_cmd_q.delete();
    exp_wdf_q.delete();
    rd_total = 0;
    wr_total = 0;
    app_hold = 0;
    wdf_hold = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 256'({app_en, app_wdf_wren, app_wdf_end, f2a_get_rd_adr,
                            f2a_get_wr_req, busy, app_cmd}), 256'(0));
    chk("reset_state", 256'(state_dbg), 256'(ST_IDLE));
    chk("reset_cnt", 256'({rd_issued_cnt, wr_issued_cnt}), 256'(0));
    chk("reset_addr_data", 256'({app_addr, app_wdf_data}), 256'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int c = 0;
    while ((rd_fifo.size() != 0 || wr_fifo.size() != 0 || exp_cmd_q.size() != 0 ||
            exp_wdf_q.size() != 0 || !m_idle) && c < budget) begin
      tick(1);
      c++;
    end
    chk(nm, 256'(c < budget), 256'(1));
  endtask

  function automatic logic [ADDR_W+2*APP_DW-1:0] rand_wr();
    logic [2*APP_DW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    return {ADDR_W'($urandom), d};
  endfunction

  initial begin : main
    int c;
    tick(2);
    do_reset(1'b0);

    // single read, app_rdy always high
    init_calib_complete = 1'b1;
    rd_fifo.push_back(27'h0000123);
    wait_drain(50, "t1_drain");
    chk("t1_rd_cnt", 256'(rd_issued_cnt), 256'(1));

    // single write with app_wdf_rdy held low for the first 3 beat-0 cycles
    wdf_hold = 3;
    wr_fifo.push_back({27'h4000000, {4{16'hBBBB}}, {4{16'hAAAA}}});
    wait_drain(50, "t2_drain");
    chk("t2_wr_cnt", 256'(wr_issued_cnt), 256'(1));

    // arbitration with both FIFOs preloaded; last grant was a write
    init_calib_complete = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_fifo.push_back(ADDR_W'($urandom));
      wr_fifo.push_back(rand_wr());
    end
    tick(2);
    pop_log.delete();
    init_calib_complete = 1'b1;
    wait_drain(200, "t3_drain");
    chk("t3_pop_count", 256'(pop_log.size()), 256'(8));
    for (int i = 0; i < 8 && i < pop_log.size(); i++)
      chk("t3_order", 256'(pop_log[i]), 256'(i % 2));

    // app_rdy stall of 5 cycles on a read command
    app_hold = 5;
    rd_fifo.push_back(ADDR_W'($urandom));
    wait_drain(50, "t4_drain");
    chk("t4_rd_cnt", 256'(rd_issued_cnt), 256'(6));

    // calibration gating
    init_calib_complete = 1'b0;
    rd_fifo.push_back(ADDR_W'($urandom));
    wr_fifo.push_back(rand_wr());
    pop_log.delete();
    tick(10);
    chk("t5_busy", 256'(busy), 256'(0));
    chk("t5_no_pop", 256'(pop_log.size()), 256'(0));
    init_calib_complete = 1'b1;
    tick(1);
    chk("t5_grant_next", 256'(pop_log.size()), 256'(1));
    wait_drain(100, "t5_drain");

    // reset while in the second write beat
    wdf_hold = 2;
    wr_fifo.push_back(rand_wr());
    c = 0;
    while (!app_wdf_end && c < 20) begin
      tick(1);
      c++;
    end
    chk("t6_reached_d1", 256'(app_wdf_end), 256'(1));
    do_reset(1'b1);
    rd_fifo.push_back(ADDR_W'($urandom));
    wait_drain(50, "t6_drain");
    chk("t6_cnts", 256'({rd_issued_cnt, wr_issued_cnt}), 256'({32'd1, 32'd0}));

    // randomized traffic with ready stalls and calibration drops
    for (int ph = 0; ph < 4; ph++) begin
      app_rdy_pct = $urandom_range(30, 100);
      wdf_rdy_pct = $urandom_range(30, 100);
      for (int k = 0; k < 400; k++) begin
        if (rd_fifo.size() < 6 && $urandom_range(99) < 30) rd_fifo.push_back(ADDR_W'($urandom));
        if (wr_fifo.size() < 6 && $urandom_range(99) < 25) wr_fifo.push_back(rand_wr());
        init_calib_complete = ($urandom_range(99) < 85);
        if ($urandom_range(99) < 5) app_hold = $urandom_range(1, 4);
        tick(1);
      end
    end
    init_calib_complete = 1'b1;
    app_rdy_pct = 100;
    wdf_rdy_pct = 100;
    wait_drain(3000, "rand_drain");
    chk("final_rd_cnt", 256'(rd_issued_cnt), 256'(32'(rd_total)));
    chk("final_wr_cnt", 256'(wr_issued_cnt), 256'(32'(wr_total)));

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ddr_fifo_to_app.md
# ddr_fifo_to_app

Command dispatcher between the DDR request FIFOs and the MIG user (app) interface. Pops read addresses from `ddr_rd_fifo` and write address/data from the write request FIFO, arbitrates round-robin, and drives `app_cmd/app_en/app_addr` and the write-data path (`app_wdf_*`) with full `app_rdy`/`app_wdf_rdy` handshaking. Read return data does not pass through this block; it flows from MIG straight back to `ddr_rd_fifo`.

## Interface
Parameters:
- `ADDR_W`, 27: app address width; also the request FIFO address width.
- `APP_DW`, 64: MIG app data width. A request carries 2×`APP_DW` bits.
- `WR_FIRST`, 0: priority after reset. 0 = read wins first tie; 1 = write wins first tie.

Ports:
- `clk` in 1: single clock, the MIG `ui_clk`.
- `reset` in 1: synchronous, active-high.
- `init_calib_complete` in 1: MIG calibration done. Nothing is granted while it is low.
- `f2a_has_rd_req` in 1: read FIFO not empty.
- `f2a_app_adx` in `ADDR_W`: read FIFO head (first-word-fall-through).
- `f2a_get_rd_adr` out 1: pops the read FIFO (1-cycle pulse).
- `f2a_has_wr_req` in 1: write FIFO not empty.
- `f2a_wr_adx` in `ADDR_W`: write FIFO head address (FWFT).
- `f2a_wr_data` in 2×`APP_DW`: write FIFO head data. `[APP_DW-1:0]` is beat 0.
- `f2a_get_wr_req` out 1: pops the write FIFO (1-cycle pulse).
- `app_addr` out `ADDR_W`.
- `app_cmd` out 3: 3'b001 = read, 3'b000 = write.
- `app_en` out 1.
- `app_rdy` in 1.
- `app_wdf_data` out `APP_DW`.
- `app_wdf_wren` out 1.
- `app_wdf_end` out 1.
- `app_wdf_mask` out `APP_DW/8`: constant 0.
- `app_wdf_rdy` in 1.
- `busy` out 1: state ≠ IDLE.
- `rd_issued_cnt` out 32: number of accepted read commands.
- `wr_issued_cnt` out 32: number of accepted write commands.

## Operation
States: IDLE, RD_CMD, WR_D0, WR_D1, WR_CMD.

- **IDLE, grant condition:** `init_calib_complete` is high and at least one `has_*` is high.
  - One requester: that requester is granted.
  - Both requesters: the side not flagged by `last_grant` is granted. `last_grant` updates on every grant and resets per `WR_FIRST`.
- **Read grant:**
  - Pulse `f2a_get_rd_adr`.
  - Latch `f2a_app_adx` into the address register.
  - Go to RD_CMD.
- **Write grant:**
  - Pulse `f2a_get_wr_req`.
  - Latch address and 128-bit data.
  - Go to WR_D0.
- **RD_CMD:** `app_en`=1, `app_cmd`=001. Stay until `app_rdy`=1, then go to IDLE and increment `rd_issued_cnt`.
- **WR_D0:** `app_wdf_wren`=1, data = beat 0, `app_wdf_end`=0. Advance to WR_D1 when `app_wdf_rdy`=1.
- **WR_D1:** `app_wdf_wren`=1, `app_wdf_end`=1, data = beat 1. Advance to WR_CMD when `app_wdf_rdy`=1.
- **WR_CMD:** `app_en`=1, `app_cmd`=000. Stay until `app_rdy`=1, then go to IDLE and increment `wr_issued_cnt`. Write data always precedes its command, which MIG permits.
- **Hold rule:** `app_addr`, `app_cmd` and `app_wdf_data` hold stable while `en`/`wren` is high and the corresponding rdy is low.
- **Counters:** wrap modulo 2^32.
- **Calibration drop:** if `init_calib_complete` falls while outside IDLE, the current transaction completes normally. Only new grants are blocked.
- **Reset:** synchronous reset at any time, including mid-write, forces IDLE and clears everything.
  - All outputs go to 0: `app_en`, `app_wdf_wren`, `app_wdf_end`, pops, `busy`, counters, `app_addr`, `app_wdf_data`.
  - `app_cmd` resets to 3'b000.
  - A popped-but-unissued request is dropped. The upstream FIFOs are reset by the same signal.

## Timing
- **Pops:** combinational from state==IDLE plus the grant condition. Exactly one cycle, and never both in the same cycle.
- **Command latency:** grant in cycle N gives `app_en` (read) or `app_wdf_wren` (write) registered high in cycle N+1.
- **Minimum issue rates:**
  - Read: 2 cycles (IDLE, RD_CMD).
  - Write: 4 cycles.
  - Back-to-back reads: one every 2 cycles.
- **Handshake completion:** a handshake completes on the rising edge where en/wren and rdy are both high. The outputs drop, or advance to the next beat, on the following cycle.
- **Counter timing:** counters update on the same edge that the command is accepted.

## Structure
- Shared package `ddr_pkg`:
  - `APP_CMD_RD`=3'b001, `APP_CMD_WR`=3'b000.
  - State encoding enum.
  - `ADDR_W` default.
- Sub-module `rr_arb2`: 2-request round-robin arbiter with grant-update enable. Kept separate so it can be reused in the write path.

## Test plan
1. **Single read:** calib=1, one read at 0x0000123, `app_rdy` tied 1 → one pop pulse, `app_en` for exactly 1 cycle with `app_addr`=0x0000123, cmd 001, `rd_issued_cnt`=1.
2. **Single write, `app_wdf_rdy` stall:** write addr 0x4000000, data {64'hBBBB..., 64'hAAAA...}, `app_wdf_rdy` low 3 cycles → beat 0 AAAA held 4 cycles, then BBBB with `app_wdf_end`=1, then `app_en` cmd 000, `wr_issued_cnt`=1.
3. **Arbitration:** both FIFOs loaded with 4 requests each, `WR_FIRST`=0 → issue order R,W,R,W,R,W,R,W; pops never coincide.
4. **`app_rdy` stall:** `app_rdy` held low 5 cycles during RD_CMD → `app_en` high 6 cycles with stable address/cmd; no second pop before acceptance.
5. **Calibration gating:** calib=0 with both FIFOs non-empty for 10 cycles → no pops, `busy`=0. Calib rising → grant on the next cycle.
6. **Reset mid-operation:** reset asserted in WR_D1 → next cycle is IDLE with all outputs 0 and counters 0. After release a new read issues normally.
